// File: rtl/alu_8_bit_ctrl.sv
// alu_8_bit_ctrl: valid/ready sequencing front-end for the 8-bit enabled ALU.
// Build option: define ALU_CTRL_ACC_EN to let operand A come from the last result.
module alu_8_bit_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_sel,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_use_acc,
  output logic       alu_en,
  output logic [2:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic       out_zero,
  output logic       out_neg,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  state_t     state;
  logic [7:0] next_a;

  // Held low during reset so nothing can be offered while rst is high.
  assign in_ready = (state == IDLE) && !rst;

`ifdef ALU_CTRL_ACC_EN
  assign next_a = in_use_acc ? out_y : in_a;
`else
  logic unused_use_acc;
  assign unused_use_acc = in_use_acc;
  assign next_a = in_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_en    <= 1'b0;
      alu_sel   <= 3'd0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      out_valid <= 1'b0;
      out_y     <= 8'h00;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      op_count  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            alu_sel <= in_sel;
            alu_a   <= next_a;
            alu_b   <= in_b;
            alu_en  <= 1'b1;
            state   <= DRIVE;
          end
        end
        // The ALU is enabled for this single cycle; its result is captured at the end.
        DRIVE: begin
          out_y     <= alu_y;
          out_zero  <= (alu_y == 8'h00);
          out_neg   <= alu_y[7];
          alu_en    <= 1'b0;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          alu_en    <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_8_bit_ctrl.sv
// tb_alu_8_bit_ctrl: randomized self-checking bench for alu_8_bit_ctrl with an ALU model.
// Follows ALU_CTRL_ACC_EN the same way the design does.
module tb_alu_8_bit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_use_acc;
  logic       alu_en;
  logic [2:0] alu_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic       out_neg;
  logic [7:0] op_count;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] expY = 8'h00;
  int         expCount = 0;
  logic [7:0] noise = 8'h00;
  logic [7:0] sweepTable [8] = '{8'h00, 8'h0F, 8'h5F, 8'h6E, 8'h30, 8'h50, 8'hB0, 8'hFF};

`ifdef ALU_CTRL_ACC_EN
  localparam bit accEn = 1'b1;
`else
  localparam bit accEn = 1'b0;
`endif

  alu_8_bit_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_en(alu_en), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_neg(out_neg), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; while disabled it drives noise instead of floating.
  function automatic logic [7:0] aluRef(input logic [2:0] sel, input logic [7:0] a,
                                        input logic [7:0] b);
    case (sel)
      3'd0:    return 8'h00;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk) noise <= 8'($urandom);
  assign alu_y = alu_en ? aluRef(alu_sel, alu_a, alu_b) : noise;

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
    end
  endtask

  // One full operation; holdCycles is how long out_ready stays low once the result is held.
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                               input logic useAcc, input int holdCycles);
    logic [7:0] aEff;
    logic [7:0] refY;
    @(negedge clk);
    in_valid   = 1'b1;
    in_sel     = sel;
    in_a       = a;
    in_b       = b;
    in_use_acc = useAcc;
    out_ready  = (holdCycles == 0);
    checkOutput("in_ready_idle", 8'(in_ready), 8'd1);
    aEff = (useAcc && accEn) ? expY : a;
    refY = aluRef(sel, aEff, b);
    @(posedge clk); #1;
    in_sel     = 3'($urandom);
    in_a       = 8'($urandom);
    in_b       = 8'($urandom);
    in_use_acc = 1'($urandom);
    checkOutput("drive_alu_en", 8'(alu_en), 8'd1);
    checkOutput("drive_in_ready", 8'(in_ready), 8'd0);
    checkOutput("drive_out_valid", 8'(out_valid), 8'd0);
    checkOutput("drive_alu_sel", 8'(alu_sel), 8'(sel));
    checkOutput("drive_alu_a", alu_a, aEff);
    checkOutput("drive_alu_b", alu_b, b);
    @(posedge clk); #1;
    checkOutput("hold_alu_en", 8'(alu_en), 8'd0);
    checkOutput("hold_out_valid", 8'(out_valid), 8'd1);
    checkOutput("hold_in_ready", 8'(in_ready), 8'd0);
    checkOutput("hold_out_y", out_y, refY);
    checkOutput("hold_out_zero", 8'(out_zero), 8'(refY == 8'h00));
    checkOutput("hold_out_neg", 8'(out_neg), 8'(refY[7]));
    expY = refY;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 8'(out_valid), 8'd1);
      checkOutput("bp_out_y", out_y, expY);
      checkOutput("bp_flags", {6'd0, out_zero, out_neg}, {6'd0, expY == 8'h00, expY[7]});
      checkOutput("bp_alu_en", 8'(alu_en), 8'd0);
      checkOutput("bp_in_ready", 8'(in_ready), 8'd0);
      checkOutput("bp_op_count", op_count, 8'(expCount));
    end
    if (holdCycles > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    expCount = (expCount + 1) % 256;
    checkOutput("done_out_valid", 8'(out_valid), 8'd0);
    checkOutput("done_in_ready", 8'(in_ready), 8'd1);
    checkOutput("done_alu_en", 8'(alu_en), 8'd0);
    checkOutput("done_op_count", op_count, 8'(expCount));
    checkOutput("done_out_y", out_y, expY);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_alu_en"}, 8'(alu_en), 8'd0);
    checkOutput({tag, "_alu_sel"}, 8'(alu_sel), 8'd0);
    checkOutput({tag, "_alu_a"}, alu_a, 8'h00);
    checkOutput({tag, "_alu_b"}, alu_b, 8'h00);
    checkOutput({tag, "_out_valid"}, 8'(out_valid), 8'd0);
    checkOutput({tag, "_out_y"}, out_y, 8'h00);
    checkOutput({tag, "_flags"}, {6'd0, out_zero, out_neg}, 8'd0);
    checkOutput({tag, "_op_count"}, op_count, 8'h00);
    checkOutput({tag, "_in_ready"}, 8'(in_ready), 8'd0);
  endtask

  // Reset with in_valid held high: nothing may be accepted while rst is high.
  task automatic resetDut(input string tag);
    @(negedge clk);
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 3'd3;
    in_a       = 8'h12;
    in_b       = 8'h34;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues(tag);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput({tag, "_release_in_ready"}, 8'(in_ready), 8'd1);
    expY     = 8'h00;
    expCount = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_a = 8'h00; in_b = 8'h00;
    in_use_acc = 1'b0; out_ready = 1'b0;
    resetDut("init");

    $display("[TB] single add");
    applyStimulus(3'd3, 8'h4F, 8'h1F, 1'b0, 0);
    checkOutput("add_result", out_y, 8'h6E);
    checkOutput("add_op_count", op_count, 8'd1);

    $display("[TB] opcode sweep");
    resetDut("sweep");
    for (int s = 0; s < 8; s++) begin
      applyStimulus(3'(s), 8'h4F, 8'h1F, 1'b0, 0);
      checkOutput("sweep_table", out_y, sweepTable[s]);
    end
    checkOutput("sweep_op_count", op_count, 8'd8);

    $display("[TB] backpressure");
    applyStimulus(3'd4, 8'h00, 8'h01, 1'b0, 10);
    checkOutput("bp_wrap_result", out_y, 8'hFF);
    checkOutput("bp_count", op_count, 8'd9);

    $display("[TB] reset during DRIVE");
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd3; in_a = 8'h10; in_b = 8'h20; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("mid_alu_en", 8'(alu_en), 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetValues("mid");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_release_in_ready", 8'(in_ready), 8'd1);
    @(posedge clk); #1;
    checkOutput("mid_no_out_valid", 8'(out_valid), 8'd0);
    checkOutput("mid_no_count", op_count, 8'd0);
    expY = 8'h00;
    expCount = 0;

    $display("[TB] accumulate chain");
    applyStimulus(3'd3, 8'h4F, 8'h1F, 1'b0, 0);
    applyStimulus(3'd3, 8'hAA, 8'h01, 1'b1, 0);
    checkOutput("acc_chain", out_y, accEn ? 8'h6F : 8'hAB);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++)
      applyStimulus(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(3, 0)));

    $display("[TB] op_count wrap");
    resetDut("wrap");
    for (int n = 0; n < 256; n++)
      applyStimulus(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
    checkOutput("wrap_op_count", op_count, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
